// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - reorder buffer allocate/writeback/read/commit signal bundle
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS 4:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

interface reorder_buffer_if #(
    parameter int ROB_ADDR_WIDTH = 3
);
    logic                      flush;
    logic                      alloc_en;
    logic                      alloc_ready;
    logic                      alloc_reg_write_en;
    logic [`REG_ADDR_BUS]      alloc_reg_write_addr;
    logic [`EXC_TYPE_BUS]      alloc_exception_type;
    logic                      alloc_is_delayslot;
    logic [`ADDR_BUS]          alloc_pc;
    logic [ROB_ADDR_WIDTH-1:0] alloc_id;
    logic                      wb_en;
    logic [ROB_ADDR_WIDTH-1:0] wb_id;
    logic [`DATA_BUS]          wb_data;
    logic [ROB_ADDR_WIDTH-1:0] read_id;
    logic                      read_done;
    logic [`DATA_BUS]          read_data;
    logic                      commit_stall;
    logic                      commit_en;
    logic                      commit_reg_write_en;
    logic [`REG_ADDR_BUS]      commit_reg_write_addr;
    logic [`DATA_BUS]          commit_data;
    logic [`EXC_TYPE_BUS]      commit_exception_type;
    logic                      commit_is_delayslot;
    logic [`ADDR_BUS]          commit_pc;
    logic                      empty;

    modport master (
        output flush, alloc_en, alloc_reg_write_en, alloc_reg_write_addr,
               alloc_exception_type, alloc_is_delayslot, alloc_pc,
               wb_en, wb_id, wb_data, read_id, commit_stall,
        input  alloc_ready, alloc_id, read_done, read_data, commit_en,
               commit_reg_write_en, commit_reg_write_addr, commit_data,
               commit_exception_type, commit_is_delayslot, commit_pc, empty
    );

    modport slave (
        input  flush, alloc_en, alloc_reg_write_en, alloc_reg_write_addr,
               alloc_exception_type, alloc_is_delayslot, alloc_pc,
               wb_en, wb_id, wb_data, read_id, commit_stall,
        output alloc_ready, alloc_id, read_done, read_data, commit_en,
               commit_reg_write_en, commit_reg_write_addr, commit_data,
               commit_exception_type, commit_is_delayslot, commit_pc, empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order alloc, out-of-order completion, in-order retire; optional macro ROB_READ_BYPASS_EN
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS 4:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module reorder_buffer #(
    parameter int ROB_ADDR_WIDTH = 3
) (
    input logic                 clk,
    input logic                 rst,
    reorder_buffer_if.slave     bus
);
    localparam int AW    = ROB_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]          head;
    logic [AW:0]          tail;
    logic [AW-1:0]        head_idx;
    logic [AW-1:0]        tail_idx;
    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     done;
    logic [DEPTH-1:0]     reg_write_en;
    logic [DEPTH-1:0]     is_delayslot;
    logic [`REG_ADDR_BUS] reg_write_addr [DEPTH];
    logic [`EXC_TYPE_BUS] exception_type [DEPTH];
    logic [`DATA_BUS]     data           [DEPTH];
    logic [`ADDR_BUS]     pc             [DEPTH];

    logic full;
    logic do_alloc;
    logic do_wb;
    logic do_commit;

    assign head_idx = head[AW-1:0];
    assign tail_idx = tail[AW-1:0];
    assign full     = (head_idx == tail_idx) && (head[AW] != tail[AW]);

    // Status, handshake and per-cycle event decode, all from registered state.
    always_comb begin
        bus.empty       = (head == tail);
        bus.alloc_ready = !full;
        bus.alloc_id    = tail_idx;
        do_alloc        = bus.alloc_en && !full;
        do_wb           = bus.wb_en && valid[bus.wb_id];
        do_commit       = valid[head_idx] && done[head_idx] && !bus.commit_stall;
    end

    // Pointers, valid/done flags and the registered retire port; flush discards the whole cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head                      <= '0;
            tail                      <= '0;
            valid                     <= '0;
            done                      <= '0;
            bus.commit_en             <= 1'b0;
            bus.commit_reg_write_en   <= 1'b0;
            bus.commit_reg_write_addr <= '0;
            bus.commit_data           <= '0;
            bus.commit_exception_type <= '0;
            bus.commit_is_delayslot   <= 1'b0;
            bus.commit_pc             <= '0;
        end else if (bus.flush) begin
            head          <= '0;
            tail          <= '0;
            valid         <= '0;
            done          <= '0;
            bus.commit_en <= 1'b0;
        end else begin
            if (do_wb) begin
                done[bus.wb_id] <= 1'b1;
            end
            // Alloc and commit never hit the same slot: that needs full (no alloc) or empty (no commit).
            if (do_alloc) begin
                valid[tail_idx] <= 1'b1;
                done[tail_idx]  <= (bus.alloc_exception_type != '0);
                tail            <= tail + PTR_ONE;
            end
            if (do_commit) begin
                valid[head_idx]           <= 1'b0;
                head                      <= head + PTR_ONE;
                bus.commit_en             <= 1'b1;
                bus.commit_reg_write_en   <= reg_write_en[head_idx] && (exception_type[head_idx] == '0);
                bus.commit_reg_write_addr <= reg_write_addr[head_idx];
                bus.commit_data           <= data[head_idx];
                bus.commit_exception_type <= exception_type[head_idx];
                bus.commit_is_delayslot   <= is_delayslot[head_idx];
                bus.commit_pc             <= pc[head_idx];
            end else begin
                bus.commit_en <= 1'b0;
            end
        end
    end

    // Entry payload; no reset needed because valid gates every consumer.
    always_ff @(posedge clk) begin
        if (rst && !bus.flush) begin
            if (do_alloc) begin
                reg_write_en[tail_idx]   <= bus.alloc_reg_write_en;
                reg_write_addr[tail_idx] <= bus.alloc_reg_write_addr;
                exception_type[tail_idx] <= bus.alloc_exception_type;
                is_delayslot[tail_idx]   <= bus.alloc_is_delayslot;
                pc[tail_idx]             <= bus.alloc_pc;
                data[tail_idx]           <= '0;
            end
            if (do_wb) begin
                data[bus.wb_id] <= bus.wb_data;
            end
        end
    end

    // Operand lookup for dispatch, optionally forwarding the writeback in flight.
    always_comb begin
        bus.read_done = valid[bus.read_id] && done[bus.read_id];
        bus.read_data = data[bus.read_id];
`ifdef ROB_READ_BYPASS_EN
        if (bus.wb_en && (bus.wb_id == bus.read_id) && valid[bus.read_id]) begin
            bus.read_done = 1'b1;
            bus.read_data = bus.wb_data;
        end
`endif
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed table plus randomized queue-model check of reorder_buffer
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS 4:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module tb_reorder_buffer;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef ROB_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reorder_buffer_if #(.ROB_ADDR_WIDTH(AW)) bus ();
    reorder_buffer #(.ROB_ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic                 alloc_en;
        logic                 rwe;
        logic [`REG_ADDR_BUS] waddr;
        logic [`EXC_TYPE_BUS] exc;
        logic                 ds;
        logic [`ADDR_BUS]     pc;
        logic                 wb_en;
        logic [AW-1:0]        wb_id;
        logic [`DATA_BUS]     wb_data;
        logic [AW-1:0]        read_id;
        logic                 stall;
        logic                 flush;
        logic                 chk_comb;
        logic                 e_ready;
        logic [AW-1:0]        e_id;
        logic                 e_empty;
        logic                 chk_read;
        logic                 e_rdone;
        logic [`DATA_BUS]     e_rdata;
        logic                 chk_commit;
        logic                 e_cen;
        logic [`ADDR_BUS]     e_cpc;
        logic [`DATA_BUS]     e_cdata;
        logic                 e_crwe;
        logic [`REG_ADDR_BUS] e_caddr;
        logic [`EXC_TYPE_BUS] e_cexc;
    } vec_t;

    typedef struct {
        logic [`ADDR_BUS]     pc;
        logic                 rwe;
        logic [`REG_ADDR_BUS] addr;
        logic [`EXC_TYPE_BUS] exc;
        logic                 ds;
        logic                 done;
        logic [`DATA_BUS]     data;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // Reference model: program-order queue of live instructions plus the tag of its front.
    ent_t q[$];
    int   head_tag;
    logic                 m_cen;
    logic                 m_rwe;
    logic [`REG_ADDR_BUS] m_addr;
    logic [`EXC_TYPE_BUS] m_exc;
    logic                 m_ds;
    logic [`ADDR_BUS]     m_pc;
    logic [`DATA_BUS]     m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pos(input logic [AW-1:0] tag);
        return (int'(tag) - head_tag + DEPTH) % DEPTH;
    endfunction

    function automatic vec_t v_idle();
        vec_t v;
        v.alloc_en = 1'b0; v.rwe = 1'b0; v.waddr = '0; v.exc = '0; v.ds = 1'b0; v.pc = '0;
        v.wb_en = 1'b0; v.wb_id = '0; v.wb_data = '0; v.read_id = '0; v.stall = 1'b0; v.flush = 1'b0;
        v.chk_comb = 1'b0; v.e_ready = 1'b0; v.e_id = '0; v.e_empty = 1'b0;
        v.chk_read = 1'b0; v.e_rdone = 1'b0; v.e_rdata = '0;
        v.chk_commit = 1'b0; v.e_cen = 1'b0; v.e_cpc = '0; v.e_cdata = '0;
        v.e_crwe = 1'b0; v.e_caddr = '0; v.e_cexc = '0;
        return v;
    endfunction

    function automatic vec_t v_alloc(input logic [31:0] pc, input logic rwe,
                                     input logic [`REG_ADDR_BUS] addr, input logic [`EXC_TYPE_BUS] exc);
        vec_t v = v_idle();
        v.alloc_en = 1'b1; v.pc = pc; v.rwe = rwe; v.waddr = addr; v.exc = exc;
        return v;
    endfunction

    function automatic vec_t v_wb(input logic [AW-1:0] id, input logic [31:0] data);
        vec_t v = v_idle();
        v.wb_en = 1'b1; v.wb_id = id; v.wb_data = data;
        return v;
    endfunction

    function automatic vec_t v_flush();
        vec_t v = v_idle();
        v.flush = 1'b1;
        return v;
    endfunction

    function automatic vec_t x_comb(input vec_t vi, input logic ready, input logic [AW-1:0] id, input logic empty);
        vec_t v = vi;
        v.chk_comb = 1'b1; v.e_ready = ready; v.e_id = id; v.e_empty = empty;
        return v;
    endfunction

    function automatic vec_t x_read(input vec_t vi, input logic [AW-1:0] rid, input logic rdone, input logic [31:0] rdata);
        vec_t v = vi;
        v.chk_read = 1'b1; v.read_id = rid; v.e_rdone = rdone; v.e_rdata = rdata;
        return v;
    endfunction

    function automatic vec_t x_nc(input vec_t vi);
        vec_t v = vi;
        v.chk_commit = 1'b1; v.e_cen = 1'b0;
        return v;
    endfunction

    function automatic vec_t x_commit(input vec_t vi, input logic [31:0] pc, input logic [31:0] data,
                                      input logic rwe, input logic [`REG_ADDR_BUS] addr, input logic [`EXC_TYPE_BUS] exc);
        vec_t v = vi;
        v.chk_commit = 1'b1; v.e_cen = 1'b1; v.e_cpc = pc; v.e_cdata = data;
        v.e_crwe = rwe; v.e_caddr = addr; v.e_cexc = exc;
        return v;
    endfunction

    function automatic void model_reset();
        q.delete();
        head_tag = 0;
        m_cen = 1'b0; m_rwe = 1'b0; m_addr = '0; m_exc = '0; m_ds = 1'b0; m_pc = '0; m_data = '0;
    endfunction

    // One clock edge of the model: decisions use the state before the edge.
    function automatic void model_step(input vec_t v);
        bit   do_commit;
        bit   was_full;
        int   p;
        ent_t c;
        ent_t n;
        if (v.flush) begin
            q.delete();
            head_tag = 0;
            m_cen = 1'b0;
            return;
        end
        was_full  = (q.size() == DEPTH);
        do_commit = (q.size() > 0) && q[0].done && !v.stall;
        if (do_commit) c = q[0];
        if (v.wb_en) begin
            p = pos(v.wb_id);
            if (p < q.size()) begin
                q[p].done = 1'b1;
                q[p].data = v.wb_data;
            end
        end
        if (v.alloc_en && !was_full) begin
            n.pc = v.pc; n.rwe = v.rwe; n.addr = v.waddr; n.exc = v.exc; n.ds = v.ds;
            n.done = (v.exc != '0); n.data = '0;
            q.push_back(n);
        end
        if (do_commit) begin
            void'(q.pop_front());
            head_tag = (head_tag + 1) % DEPTH;
            m_cen = 1'b1; m_rwe = c.rwe && (c.exc == '0); m_addr = c.addr;
            m_exc = c.exc; m_ds = c.ds; m_pc = c.pc; m_data = c.data;
        end else begin
            m_cen = 1'b0;
        end
    endfunction

    task automatic check_comb(input vec_t v);
        int sz;
        int p;
        logic vld;
        logic rd;
        logic [31:0] rdat;
        sz = q.size();
        chk("alloc_ready", 32'(bus.alloc_ready), 32'(sz < DEPTH));
        chk("alloc_id", 32'(bus.alloc_id), (head_tag + sz) % DEPTH);
        chk("empty", 32'(bus.empty), 32'(sz == 0));
        p = pos(v.read_id);
        vld = (p < sz);
        rd = 1'b0;
        rdat = '0;
        if (vld) begin
            rd = q[p].done;
            rdat = q[p].data;
        end
        if (BYP && v.wb_en && (v.wb_id == v.read_id) && vld) begin
            rd = 1'b1;
            rdat = v.wb_data;
        end
        chk("read_done", 32'(bus.read_done), 32'(rd));
        if (vld) chk("read_data", bus.read_data, rdat);
        if (v.chk_comb) begin
            chk("tbl_alloc_ready", 32'(bus.alloc_ready), 32'(v.e_ready));
            chk("tbl_alloc_id", 32'(bus.alloc_id), 32'(v.e_id));
            chk("tbl_empty", 32'(bus.empty), 32'(v.e_empty));
        end
        if (v.chk_read) begin
            chk("tbl_read_done", 32'(bus.read_done), 32'(v.e_rdone));
            if (v.e_rdone) chk("tbl_read_data", bus.read_data, v.e_rdata);
        end
    endtask

    task automatic check_commit(input vec_t v);
        chk("commit_en", 32'(bus.commit_en), 32'(m_cen));
        chk("commit_reg_write_en", 32'(bus.commit_reg_write_en), 32'(m_rwe));
        chk("commit_reg_write_addr", 32'(bus.commit_reg_write_addr), 32'(m_addr));
        chk("commit_exception_type", 32'(bus.commit_exception_type), 32'(m_exc));
        chk("commit_is_delayslot", 32'(bus.commit_is_delayslot), 32'(m_ds));
        chk("commit_pc", bus.commit_pc, m_pc);
        chk("commit_data", bus.commit_data, m_data);
        if (v.chk_commit) begin
            chk("tbl_commit_en", 32'(bus.commit_en), 32'(v.e_cen));
            if (v.e_cen) begin
                chk("tbl_commit_pc", bus.commit_pc, v.e_cpc);
                chk("tbl_commit_data", bus.commit_data, v.e_cdata);
                chk("tbl_commit_rwe", 32'(bus.commit_reg_write_en), 32'(v.e_crwe));
                chk("tbl_commit_addr", 32'(bus.commit_reg_write_addr), 32'(v.e_caddr));
                chk("tbl_commit_exc", 32'(bus.commit_exception_type), 32'(v.e_cexc));
            end
        end
    endtask

    task automatic drive(input vec_t v);
        bus.alloc_en             = v.alloc_en;
        bus.alloc_reg_write_en   = v.rwe;
        bus.alloc_reg_write_addr = v.waddr;
        bus.alloc_exception_type = v.exc;
        bus.alloc_is_delayslot   = v.ds;
        bus.alloc_pc             = v.pc;
        bus.wb_en                = v.wb_en;
        bus.wb_id                = v.wb_id;
        bus.wb_data              = v.wb_data;
        bus.read_id              = v.read_id;
        bus.commit_stall         = v.stall;
        bus.flush                = v.flush;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic run_cycle(input vec_t v);
        drive(v);
        #1;
        check_comb(v);
        @(posedge clk);
        model_step(v);
        #1;
        check_commit(v);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        // Fill: ids 0..7, then a refused 9th allocation.
        for (int i = 0; i < 8; i++)
            tbl.push_back(x_nc(x_comb(v_alloc(32'hbfc00000 + 32'(4 * i), 1'b1, 5'(i + 1), 5'd0),
                                      1'b1, 3'(i), 1'(i == 0))));
        tbl.push_back(x_nc(x_comb(v_alloc(32'hbfc00020, 1'b1, 5'd9, 5'd0), 1'b0, 3'd0, 1'b0)));
        // Out-of-order completion, in-order retirement.
        tbl.push_back(x_nc(x_comb(v_wb(3'd2, 32'h3), 1'b0, 3'd0, 1'b0)));
        tbl.push_back(x_nc(x_comb(v_wb(3'd1, 32'h2), 1'b0, 3'd0, 1'b0)));
        tbl.push_back(x_nc(x_comb(v_wb(3'd0, 32'h1), 1'b0, 3'd0, 1'b0)));
        tbl.push_back(x_commit(v_idle(), 32'hbfc00000, 32'h1, 1'b1, 5'd1, 5'd0));
        tbl.push_back(x_commit(v_idle(), 32'hbfc00004, 32'h2, 1'b1, 5'd2, 5'd0));
        tbl.push_back(x_commit(v_idle(), 32'hbfc00008, 32'h3, 1'b1, 5'd3, 5'd0));
        tbl.push_back(x_nc(v_idle()));
        // Excepting instruction retires without writeback and without a regfile write.
        tbl.push_back(x_nc(v_flush()));
        tbl.push_back(x_nc(x_comb(v_alloc(32'hbfc00100, 1'b1, 5'd10, 5'd5), 1'b1, 3'd0, 1'b1)));
        tbl.push_back(x_commit(v_idle(), 32'hbfc00100, 32'h0, 1'b0, 5'd10, 5'd5));
        // Full ROB: commit and refused alloc in the same cycle, alloc accepted next at id 0.
        tbl.push_back(x_nc(v_flush()));
        for (int i = 0; i < 8; i++)
            tbl.push_back(x_comb(v_alloc(32'hbfc00200 + 32'(4 * i), 1'b1, 5'(i), 5'd0),
                                 1'b1, 3'(i), 1'(i == 0)));
        tbl.push_back(x_nc(x_comb(v_wb(3'd0, 32'haa), 1'b0, 3'd0, 1'b0)));
        tbl.push_back(x_commit(x_comb(v_alloc(32'hbfc00300, 1'b1, 5'd20, 5'd0), 1'b0, 3'd0, 1'b0),
                               32'hbfc00200, 32'haa, 1'b1, 5'd0, 5'd0));
        tbl.push_back(x_nc(x_comb(v_alloc(32'hbfc00304, 1'b1, 5'd21, 5'd0), 1'b1, 3'd0, 1'b0)));
        tbl.push_back(x_nc(x_comb(v_idle(), 1'b0, 3'd1, 1'b0)));
        // Flush with four live entries, tag 1 done; flush-cycle alloc/wb and a late wb are dropped.
        tbl.push_back(x_nc(v_flush()));
        for (int i = 0; i < 4; i++)
            tbl.push_back(x_comb(v_alloc(32'h00000400 + 32'(4 * i), 1'b0, 5'd0, 5'd0), 1'b1, 3'(i), 1'(i == 0)));
        tbl.push_back(x_comb(v_wb(3'd1, 32'h55), 1'b1, 3'd4, 1'b0));
        tbl.push_back(x_read(v_idle(), 3'd1, 1'b1, 32'h55));
        v = v_alloc(32'h00000500, 1'b1, 5'd3, 5'd0);
        v.flush = 1'b1; v.wb_en = 1'b1; v.wb_id = 3'd2; v.wb_data = 32'h77;
        tbl.push_back(x_nc(v));
        tbl.push_back(x_nc(x_read(x_comb(v_wb(3'd1, 32'h66), 1'b1, 3'd0, 1'b1), 3'd1, 1'b0, 32'h0)));
        tbl.push_back(x_nc(x_read(x_comb(v_idle(), 1'b1, 3'd0, 1'b1), 3'd1, 1'b0, 32'h0)));
        // Writeback visibility on the read port with and without forwarding.
        for (int i = 0; i < 4; i++)
            tbl.push_back(x_comb(v_alloc(32'h00000600 + 32'(4 * i), 1'b1, 5'(i), 5'd0), 1'b1, 3'(i), 1'(i == 0)));
        tbl.push_back(x_read(v_idle(), 3'd3, 1'b0, 32'h0));
        tbl.push_back(x_read(v_wb(3'd3, 32'h12345678), 3'd3, BYP, BYP ? 32'h12345678 : 32'h0));
        tbl.push_back(x_read(v_idle(), 3'd3, 1'b1, 32'h12345678));

        rst = 1'b0;
        drive(v_idle());
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_comb(v_idle());
        check_commit(v_idle());
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_cycle(tbl[i]);

        for (int i = 0; i < 3000; i++) begin
            v = v_idle();
            v.alloc_en = 1'($urandom_range(0, 9) < 7);
            v.rwe      = 1'($urandom_range(0, 1));
            v.waddr    = 5'($urandom_range(0, 31));
            v.exc      = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            v.ds       = 1'($urandom_range(0, 1));
            v.pc       = $urandom;
            v.wb_en    = 1'($urandom_range(0, 1));
            v.wb_id    = 3'($urandom_range(0, 7));
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                v.wb_id = 3'((head_tag + int'($urandom_range(0, q.size() - 1))) % DEPTH);
            v.wb_data  = $urandom;
            v.read_id  = ($urandom_range(0, 1) == 0) ? v.wb_id : 3'($urandom_range(0, 7));
            v.stall    = 1'($urandom_range(0, 3) == 0);
            v.flush    = 1'($urandom_range(0, 59) == 0);
            run_cycle(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
